// File: rtl/fir_filter_tdm.sv
// Time-multiplexed FIR filter: one signed MAC iterated over TAPS cycles per sample,
// runtime-loadable coefficients, valid/ready handshakes, optional rounding, saturating output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a sample; coefficient writes accepted here only
// MAC   | accumulating x[k]*c[k] for k = 0..TAPS-1, one tap per cycle
// OUT   | scale, round and clamp the accumulator into out_data/sat
// HOLD  | out_valid high until downstream takes the sample
`timescale 1ns/1ps
module fir_filter_tdm #(
   parameter int WIDTH  = 9,
   parameter int COEF_W = 9,
   parameter int TAPS   = 33,
   parameter int ACC_W  = 24,
   parameter int FRAC   = 8,
   parameter int RND    = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic signed [WIDTH-1:0]    in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic signed [WIDTH-1:0]    out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       coef_we,
   input  logic [$clog2(TAPS)-1:0]    coef_addr,
   input  logic signed [COEF_W-1:0]   coef_data,
   output logic                       sat,
   output logic                       busy
);

   localparam int KW = $clog2(TAPS);
   localparam int PW = WIDTH + COEF_W;
   localparam logic [KW-1:0]          K_LAST  = KW'(TAPS - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX  = ACC_W'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN  = ACC_W'(-(2 ** (WIDTH - 1)));
   localparam logic signed [ACC_W-1:0] RND_ADD =
      ((RND != 0) && (FRAC > 0)) ? ACC_W'(2 ** (FRAC - 1)) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic signed [WIDTH-1:0]    x_q [TAPS];
   logic signed [COEF_W-1:0]   c_q [TAPS];
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [KW-1:0]              k_q, k_d;
   logic signed [WIDTH-1:0]    out_data_q, out_data_d;
   logic                       out_valid_q, out_valid_d;
   logic                       sat_q, sat_d;
   logic                       shift_en;
   logic                       coef_wr;

   logic signed [PW-1:0]       prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    y_rnd;
   logic signed [ACC_W-1:0]    y_shift;

   // Full-precision product, sign-extended so the accumulator can never wrap.
   assign prod     = x_q[k_q] * c_q[k_q];
   assign prod_ext = ACC_W'(prod);
   assign y_rnd    = acc_q + RND_ADD;
   assign y_shift  = y_rnd >>> FRAC;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      k_d         = k_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      sat_d       = sat_q;
      shift_en    = 1'b0;
      coef_wr     = 1'b0;

      case (state_q)
         S_IDLE: begin
            coef_wr = coef_we && (int'(coef_addr) < TAPS);
            if (in_valid) begin
               shift_en = 1'b1;
               acc_d    = '0;
               k_d      = '0;
               state_d  = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_q + prod_ext;
            if (k_q == K_LAST) begin
               state_d = S_OUT;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_OUT: begin
            if (y_shift > Y_MAX) begin
               out_data_d = Y_MAX[WIDTH-1:0];
               sat_d      = 1'b1;
            end else if (y_shift < Y_MIN) begin
               out_data_d = Y_MIN[WIDTH-1:0];
               sat_d      = 1'b1;
            end else begin
               out_data_d = y_shift[WIDTH-1:0];
               sat_d      = 1'b0;
            end
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         k_q         <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         k_q         <= k_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
      end
   end

   // Delay line and coefficient bank; a same-cycle write lands before MAC reads it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            c_q[i] <= '0;
         end
      end else begin
         if (shift_en) begin
            for (int i = TAPS - 1; i > 0; i--) begin
               x_q[i] <= x_q[i-1];
            end
            x_q[0] <= in_data;
         end
         if (coef_wr) begin
            c_q[coef_addr] <= coef_data;
         end
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign sat       = sat_q;

endmodule
